// File: rtl/json_cmd_serializer_if.sv
// Command-frame input and byte-stream output of the JSON serializer.
interface json_cmd_serializer_if #(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned VAL_W  = 12
);
  logic [3:0]              cmd_type;
  logic [NUM_CH*VAL_W-1:0] ch_value;
  logic                    cmd_valid;
  logic                    cmd_ready;
  logic [7:0]              out_data;
  logic                    out_valid;
  logic                    out_ready;
  logic                    frame_done;
  logic                    busy;

  // Frame producer / UART side
  modport master (
    output cmd_type, ch_value, cmd_valid, out_ready,
    input  cmd_ready, out_data, out_valid, frame_done, busy
  );

  // Serializer side
  modport slave (
    input  cmd_type, ch_value, cmd_valid, out_ready,
    output cmd_ready, out_data, out_valid, frame_done, busy
  );
endinterface

// File: rtl/json_cmd_serializer.sv
// Latches a command frame, converts each channel to BCD by double-dabble and
// streams a fixed-length JSON line ({"T":t,"n":sd.dd,...}\n) byte by byte.
// An optional heartbeat resends the last latched frame after an idle period.
module json_cmd_serializer #(
  parameter int unsigned         NUM_CH           = 2,
  parameter int unsigned         VAL_W            = 12,
  parameter logic [NUM_CH*8-1:0] CH_NAMES         = "LR",
  parameter int unsigned         MAX_TYPE         = 3,
  parameter int unsigned         HEARTBEAT_CYCLES = 0
) (
  input logic                  clk,
  input logic                  reset,
  json_cmd_serializer_if.slave bus
);

  localparam int unsigned FLEN  = 8 + 10 * NUM_CH;
  localparam int unsigned IDX_W = $clog2(FLEN);
  localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned HB_W  = (HEARTBEAT_CYCLES > 0) ? $clog2(HEARTBEAT_CYCLES + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CONVERT,
    S_SEND
  } state_t;

  state_t r_state;
  state_t w_next;

  // Latched, sanitised frame
  logic [3:0]                r_type;
  logic [NUM_CH-1:0]         r_neg;
  logic [NUM_CH-1:0][9:0]    r_mag;
  logic [NUM_CH-1:0][11:0]   r_bcd;

  // Conversion state
  logic [21:0]     r_sh;
  logic [3:0]      r_bit;
  logic [CH_W-1:0] r_ch;

  logic [IDX_W-1:0] r_byte_idx;
  logic [HB_W-1:0]  r_hb_cnt;
  logic             r_frame_done;

  logic w_accept;
  logic w_hb_fire;
  logic w_conv_last;
  logic w_byte_take;
  logic w_last_byte;

  logic [NUM_CH-1:0][VAL_W:0] w_wide;
  logic [NUM_CH-1:0][VAL_W:0] w_abs;
  logic [NUM_CH-1:0][9:0]     w_mag;
  logic [NUM_CH-1:0]          w_neg;
  logic                       w_stop;

  logic [21:0] w_src;
  logic [21:0] w_adj;
  logic [21:0] w_shift;

  logic [31:0] w_idx;
  logic [31:0] w_off;
  logic [7:0]  w_byte;

  assign w_accept    = bus.cmd_valid && (r_state == S_IDLE);
  assign w_hb_fire   = (HEARTBEAT_CYCLES != 0) && (r_state == S_IDLE) &&
                       (r_hb_cnt == HB_W'(HEARTBEAT_CYCLES));
  assign w_conv_last = (r_state == S_CONVERT) && (r_bit == 4'd9) &&
                       (r_ch == CH_W'(NUM_CH - 1));
  assign w_byte_take = (r_state == S_SEND) && bus.out_ready;
  assign w_last_byte = w_byte_take && (r_byte_idx == IDX_W'(FLEN - 1));

  // Sanitise incoming values: illegal type forces the stop frame, magnitudes clip at 999
  always_comb begin
    w_stop = (bus.cmd_type > 4'(MAX_TYPE));
    w_wide = '0;
    w_abs  = '0;
    w_mag  = '0;
    w_neg  = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      w_wide[i] = {bus.ch_value[i*VAL_W + VAL_W - 1], bus.ch_value[i*VAL_W +: VAL_W]};
      w_abs[i]  = w_wide[i][VAL_W] ? (~w_wide[i]) + (VAL_W + 1)'(1) : w_wide[i];
      if (!w_stop) begin
        w_neg[i] = w_wide[i][VAL_W];
        w_mag[i] = (w_abs[i] > (VAL_W + 1)'(999)) ? 10'd999 : w_abs[i][9:0];
      end
    end
  end

  // One double-dabble step: load on the first bit, add-3 on BCD digits >= 5, shift left
  always_comb begin
    w_src = (r_bit == 4'd0) ? {12'd0, r_mag[r_ch]} : r_sh;
    w_adj = w_src;
    for (int unsigned d = 0; d < 3; d++) begin
      if (w_src[10 + 4*d +: 4] >= 4'd5) begin
        w_adj[10 + 4*d +: 4] = w_src[10 + 4*d +: 4] + 4'd3;
      end
    end
    w_shift = w_adj << 1;
  end

  // Byte selected by the current frame index
  always_comb begin
    w_idx  = 32'(r_byte_idx);
    w_off  = '0;
    w_byte = 8'h00;
    if (w_idx == 32'd0)              w_byte = "{";
    else if (w_idx == 32'd1)         w_byte = "\"";
    else if (w_idx == 32'd2)         w_byte = "T";
    else if (w_idx == 32'd3)         w_byte = "\"";
    else if (w_idx == 32'd4)         w_byte = ":";
    else if (w_idx == 32'd5)         w_byte = 8'h30 + {4'h0, r_type};
    else if (w_idx == FLEN - 2)      w_byte = "}";
    else if (w_idx == FLEN - 1)      w_byte = 8'h0A;
    else begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        if (w_idx >= 6 + 10*i && w_idx < 16 + 10*i) begin
          w_off = w_idx - (6 + 10*i);
          case (w_off)
            32'd0:   w_byte = ",";
            32'd1:   w_byte = "\"";
            32'd2:   w_byte = CH_NAMES[8*(NUM_CH - 1 - i) +: 8];
            32'd3:   w_byte = "\"";
            32'd4:   w_byte = ":";
            32'd5:   w_byte = r_neg[i] ? "-" : " ";
            32'd6:   w_byte = 8'h30 + {4'h0, r_bcd[i][11:8]};
            32'd7:   w_byte = ".";
            32'd8:   w_byte = 8'h30 + {4'h0, r_bcd[i][7:4]};
            default: w_byte = 8'h30 + {4'h0, r_bcd[i][3:0]};
          endcase
        end
      end
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next state: a command beats a heartbeat due in the same cycle
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept)       w_next = S_CONVERT;
        else if (w_hb_fire) w_next = S_SEND;
      end
      S_CONVERT: if (w_conv_last) w_next = S_SEND;
      S_SEND:    if (w_last_byte) w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    bus.cmd_ready  = (r_state == S_IDLE);
    bus.busy       = (r_state != S_IDLE);
    bus.out_valid  = (r_state == S_SEND);
    bus.out_data   = (r_state == S_SEND) ? w_byte : 8'h00;
    bus.frame_done = r_frame_done;
  end

  // Frame latch, BCD conversion, byte index and heartbeat counter
  always_ff @(posedge clk) begin
    if (reset) begin
      r_type       <= '0;
      r_neg        <= '0;
      r_mag        <= '0;
      r_bcd        <= '0;
      r_sh         <= '0;
      r_bit        <= '0;
      r_ch         <= '0;
      r_byte_idx   <= '0;
      r_hb_cnt     <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_last_byte;

      if (w_accept) begin
        r_type <= w_stop ? 4'd0 : bus.cmd_type;
        r_neg  <= w_neg;
        r_mag  <= w_mag;
        r_bit  <= '0;
        r_ch   <= '0;
      end

      if (r_state == S_CONVERT) begin
        r_sh <= w_shift;
        if (r_bit == 4'd9) begin
          r_bcd[r_ch] <= w_shift[21:10];
          r_bit       <= '0;
          r_ch        <= w_conv_last ? '0 : r_ch + CH_W'(1);
        end else begin
          r_bit <= r_bit + 4'd1;
        end
      end

      if (r_state != S_SEND)  r_byte_idx <= '0;
      else if (w_last_byte)   r_byte_idx <= '0;
      else if (w_byte_take)   r_byte_idx <= r_byte_idx + IDX_W'(1);

      if ((HEARTBEAT_CYCLES != 0) && (r_state == S_IDLE) && !w_accept && !w_hb_fire)
        r_hb_cnt <= r_hb_cnt + HB_W'(1);
      else
        r_hb_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_json_cmd_serializer.sv
// Directed bench for json_cmd_serializer: a default 2-channel instance and a
// 3-channel instance with a 100-cycle heartbeat.
module tb_json_cmd_serializer;

  logic clk;
  logic rst0;
  logic rst1;
  logic rdy;
  logic sel;

  logic       m_valid;
  logic [7:0] m_data;
  logic       m_ready;
  logic       m_done;
  logic       m_busy;

  int n_pass;
  int n_total;

  int inj_t;
  int inj_v0;
  int inj_v1;

  localparam string F1  = "{\"T\":1,\"L\":-0.10,\"R\":-0.05}\n";
  localparam string F3  = "{\"T\":0,\"L\": 0.00,\"R\": 0.00}\n";
  localparam string F4  = "{\"T\":2,\"L\": 9.99,\"R\":-9.99}\n";
  localparam string F5  = "{\"T\":3,\"L\":-0.30,\"R\":-0.30}\n";
  localparam string FS3 = "{\"T\":0,\"L\": 0.00,\"R\": 0.00,\"S\": 0.00}\n";
  localparam string FA3 = "{\"T\":2,\"L\": 1.23,\"R\":-9.99,\"S\": 0.05}\n";
  localparam string FB3 = "{\"T\":1,\"L\":-0.01,\"R\": 0.00,\"S\": 9.99}\n";

  json_cmd_serializer_if #(.NUM_CH(2), .VAL_W(12)) bus0 ();
  json_cmd_serializer_if #(.NUM_CH(3), .VAL_W(12)) bus1 ();

  json_cmd_serializer #(
    .NUM_CH(2), .VAL_W(12), .CH_NAMES("LR"), .MAX_TYPE(3), .HEARTBEAT_CYCLES(0)
  ) u_dut (
    .clk   (clk),
    .reset (rst0),
    .bus   (bus0)
  );

  json_cmd_serializer #(
    .NUM_CH(3), .VAL_W(12), .CH_NAMES("LRS"), .MAX_TYPE(3), .HEARTBEAT_CYCLES(100)
  ) u_hb (
    .clk   (clk),
    .reset (rst1),
    .bus   (bus1)
  );

  assign bus0.out_ready = rdy;
  assign bus1.out_ready = rdy;

  always_comb begin
    if (sel) begin
      m_valid = bus1.out_valid;
      m_data  = bus1.out_data;
      m_ready = bus1.cmd_ready;
      m_done  = bus1.frame_done;
      m_busy  = bus1.busy;
    end else begin
      m_valid = bus0.out_valid;
      m_data  = bus0.out_data;
      m_ready = bus0.cmd_ready;
      m_done  = bus0.frame_done;
      m_busy  = bus0.busy;
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic drive_cmd(input int t, input int v0, input int v1, input int v2);
    bus0.cmd_type = 4'(t);
    bus1.cmd_type = 4'(t);
    bus0.ch_value = {12'(v1), 12'(v0)};
    bus1.ch_value = {12'(v2), 12'(v1), 12'(v0)};
    if (sel) bus1.cmd_valid = 1'b1;
    else     bus0.cmd_valid = 1'b1;
  endtask

  task automatic drop_cmd();
    bus0.cmd_valid = 1'b0;
    bus1.cmd_valid = 1'b0;
  endtask

  // Offers a frame at the next falling edge and returns just after it is accepted
  task automatic send_cmd(input int t, input int v0, input int v1, input int v2);
    int k = 0;
    @(negedge clk);
    drive_cmd(t, v0, v1, v2);
    while (!m_ready && k < 500) begin
      @(negedge clk);
      k++;
    end
    if (!m_ready) chk("accept_wait", {31'd0, m_ready}, 32'd1);
    @(posedge clk);
    #1;
    drop_cmd();
  endtask

  // Receives one frame; exp_lat counts falling edges from entry to the first valid byte
  task automatic recv_frame(input string tag, input string exp, input int exp_lat,
                            input bit stall, input int inject_at);
    int         got = 0;
    int         k = 0;
    bit         seen = 1'b0;
    bit         prev_stall = 1'b0;
    bit         tog = 1'b1;
    bit         injected = 1'b0;
    logic [7:0] held = '0;
    while (got < exp.len() && k < 3000) begin
      @(negedge clk);
      k++;
      if (m_valid && !seen) begin
        seen = 1'b1;
        if (exp_lat > 0) chk({tag, "_lat"}, k, exp_lat);
      end
      if (prev_stall) chk({tag, "_hold"}, {24'd0, m_data}, {24'd0, held});
      if (seen) begin
        chk({tag, "_vld"}, {31'd0, m_valid}, 32'd1);
        chk({tag, "_cmd_rdy"}, {31'd0, m_ready}, 32'd0);
        chk({tag, "_done_early"}, {31'd0, m_done}, 32'd0);
      end
      if (inject_at >= 0 && got == inject_at && seen && !injected) begin
        drive_cmd(inj_t, inj_v0, inj_v1, 0);
        injected = 1'b1;
      end
      rdy = stall ? tog : 1'b1;
      tog = !tog;
      if (m_valid && rdy) begin
        chk($sformatf("%s_b%0d", tag, got), {24'd0, m_data}, {24'd0, exp[got]});
        got++;
      end
      prev_stall = m_valid && !rdy;
      held = m_data;
    end
    if (got < exp.len()) chk({tag, "_timeout"}, got, exp.len());
    @(negedge clk);
    chk({tag, "_done"}, {31'd0, m_done}, 32'd1);
    chk({tag, "_idle_rdy"}, {31'd0, m_ready}, 32'd1);
    rdy = 1'b1;
  endtask

  initial begin
    int k;
    n_pass  = 0;
    n_total = 0;
    sel  = 1'b0;
    rdy  = 1'b1;
    rst0 = 1'b1;
    rst1 = 1'b1;
    inj_t = 0; inj_v0 = 0; inj_v1 = 0;
    bus0.cmd_type = '0; bus0.ch_value = '0; bus0.cmd_valid = 1'b0;
    bus1.cmd_type = '0; bus1.ch_value = '0; bus1.cmd_valid = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_cmd_ready",  {31'd0, m_ready}, 32'd1);
    chk("rst_out_valid",  {31'd0, m_valid}, 32'd0);
    chk("rst_out_data",   {24'd0, m_data},  32'd0);
    chk("rst_frame_done", {31'd0, m_done},  32'd0);
    chk("rst_busy",       {31'd0, m_busy},  32'd0);
    rst0 = 1'b0;

    // Basic frame at full rate, single frame_done pulse
    send_cmd(1, -10, -5, 0);
    recv_frame("t1", F1, 21, 1'b0, -1);
    @(negedge clk);
    chk("t1_done_pulse", {31'd0, m_done}, 32'd0);

    // Same frame under alternating backpressure
    send_cmd(1, -10, -5, 0);
    recv_frame("t2", F1, 21, 1'b1, -1);

    // Illegal type becomes the stop frame
    send_cmd(7, 50, -30, 0);
    recv_frame("t3", F3, 21, 1'b0, -1);

    // Extreme values saturate to 9.99
    send_cmd(2, 2047, -2048, 0);
    recv_frame("t4", F4, 21, 1'b0, -1);

    // Command offered mid-frame waits for frame_done
    send_cmd(1, -10, -5, 0);
    inj_t = 3; inj_v0 = -30; inj_v1 = -30;
    recv_frame("t5a", F1, 21, 1'b0, 20);
    @(posedge clk);
    #1;
    drop_cmd();
    recv_frame("t5b", F5, 21, 1'b0, -1);

    // Heartbeat instance: stop frame after reset, then resend of latched frame
    sel = 1'b1;
    @(negedge clk);
    rst1 = 1'b0;
    recv_frame("hb_boot", FS3, 101, 1'b0, -1);
    send_cmd(2, 123, -999, 5);
    recv_frame("hb_cmd", FA3, 31, 1'b0, -1);
    recv_frame("hb_resend", FA3, 101, 1'b0, -1);

    // Command offered in the cycle the heartbeat would fire takes priority
    repeat (99) @(negedge clk);
    send_cmd(1, -1, 0, 999);
    recv_frame("hb_preempt", FB3, 31, 1'b0, -1);

    // Reset during a heartbeat frame aborts it
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!m_valid && k < 300);
    chk("hb_mid_lat", k, 101);
    repeat (4) @(negedge clk);
    chk("hb_mid_vld", {31'd0, m_valid}, 32'd1);
    rst1 = 1'b1;
    @(negedge clk);
    chk("hb_rst_vld",  {31'd0, m_valid}, 32'd0);
    chk("hb_rst_busy", {31'd0, m_busy},  32'd0);
    rst1 = 1'b0;
    recv_frame("hb_post_rst", FS3, 101, 1'b0, -1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/json_cmd_serializer.md
Name: json_cmd_serializer

Overview:
- Parametrised successor to the single-command ASCII translator.
- Accepts a command frame with a type digit plus NUM_CH signed channel values in hundredths. Latches the frame, converts the values to BCD iteratively, then streams a fixed-length JSON line byte by byte to the UART transmitter through a valid/ready handshake.
- Adds per-channel naming, saturation, output backpressure and an optional heartbeat that retransmits the last frame.

Parameters:
- NUM_CH, 2, number of channel fields per frame (1..8).
- VAL_W, 12, width of each signed channel value (two's complement, hundredths); must be >= 11.
- CH_NAMES, "LR", NUM_CH*8-bit ASCII names. Channel i name = CH_NAMES[8*(NUM_CH-1-i) +: 8]; channel 0 is emitted first.
- MAX_TYPE, 3, largest legal cmd_type (<= 9).
- HEARTBEAT_CYCLES, 0, idle cycles before the latched frame is resent; 0 disables heartbeat.

Ports:
- clk, input, 1, system clock.
- reset, input, 1, synchronous active-high reset.
- cmd_type, input, 4, command type digit.
- ch_value, input, NUM_CH*VAL_W, channel i at [i*VAL_W +: VAL_W], signed hundredths.
- cmd_valid, input, 1, command frame offered.
- cmd_ready, output, 1, block can accept a frame.
- out_data, output, 8, ASCII byte.
- out_valid, output, 1, out_data valid.
- out_ready, input, 1, UART can take the byte.
- frame_done, output, 1, one-cycle pulse when the final byte ('\n') is accepted.
- busy, output, 1, high in CONVERT or SEND.

Behaviour:
- Reset (synchronous, active-high):
  - State is IDLE.
  - Outputs: cmd_ready=1, out_valid=0, out_data=0x00, frame_done=0, busy=0.
  - Latched frame is the stop frame (type 0, all values 0). Heartbeat counter is 0.
  - Reset mid-frame aborts the frame; no further bytes are sent.
- Frame format, fixed length 8+10*NUM_CH bytes:
  - Header: '{"T":' then the type digit.
  - Per channel: ',"' name '":' sign d '.' d d.
  - Trailer: '}' then 0x0A.
  - Sign character is '-' (0x2D) for negative and ' ' (0x20) for zero/positive.
  - Example for NUM_CH=2: {"T":1,"L":-0.10,"R":-0.05}\n, 28 bytes.
- Accept: a frame is taken on a clock edge where cmd_valid && cmd_ready. cmd_ready is high only in IDLE. Inputs are sampled once and are ignored until the next accept.
- Sanitising, applied at latch:
  - If cmd_type > MAX_TYPE, the whole frame becomes the stop frame.
  - Otherwise each value's magnitude saturates to 999. Magnitude of the most-negative value is computed without overflow (widen by 1 bit).
- States: IDLE -> CONVERT -> SEND -> IDLE.
- CONVERT:
  - Double-dabble, 10 shift cycles per channel, channels sequential.
  - Lasts exactly 10*NUM_CH cycles.
  - out_valid rises on the cycle after the last conversion cycle. For NUM_CH=2, the first byte is valid 21 cycles after the accept edge.
- SEND:
  - Byte index advances only on out_valid && out_ready.
  - out_data must be stable while out_valid && !out_ready.
  - out_valid stays high for the whole frame; there are no gaps when out_ready is held high.
  - One byte per cycle at full rate.
- End of frame:
  - On acceptance of 0x0A: frame_done=1 for that cycle's next cycle.
  - State returns to IDLE, so cmd_ready=1 on the same cycle frame_done is high.
- Heartbeat (HEARTBEAT_CYCLES>0):
  - The counter increments every cycle in IDLE and clears on any accept or frame end.
  - When it reaches HEARTBEAT_CYCLES, the FSM enters SEND directly with the stored BCD of the latched frame; no reconversion.
  - A command arriving in the same cycle wins and the heartbeat is suppressed.
  - After reset with no command, the heartbeat sends the stop frame.
- Widths:
  - Byte counter is sized for 8+10*NUM_CH.
  - BCD storage is 3 digits plus a sign bit per channel.

Test Plan:
1. Reset, then cmd_type=1 with L=-10, R=-5, out_ready=1. Required: first out_valid 21 cycles after accept; 28 consecutive bytes {"T":1,"L":-0.10,"R":-0.05}\n; a single frame_done; cmd_ready low during transmission.
2. Same command with out_ready alternating 1/0 each cycle. Required: identical 28 bytes, no byte duplicated or dropped, out_data constant across every stall.
3. cmd_type=7 with L=50, R=-30. Required: stop frame {"T":0,"L": 0.00,"R": 0.00}\n.
4. cmd_type=2 with L=2047, R=-2048. Required: saturated output {"T":2,"L": 9.99,"R":-9.99}\n.
5. New cmd_valid (type 3, L=-30, R=-30) asserted at byte 20 of an in-progress frame. Required: the in-progress frame completes unchanged; the new command is accepted on the frame_done cycle and the next frame carries -0.30/-0.30.
6. With HEARTBEAT_CYCLES=100, NUM_CH=3, CH_NAMES="LRS":
   - An idle cycle count reaching 100 after frame_done resends the identical 38-byte frame.
   - cmd_valid at idle cycle 99 pre-empts the heartbeat.
   - A reset asserted mid-heartbeat drops out_valid on the next cycle.
